// File: rtl/mult_pkg.sv
// Shared widths and types for the 4x4 unsigned array multiplier.
package mult_pkg;
  localparam int A_W = 4;
  localparam int B_W = 4;
  localparam int P_W = A_W + B_W;

  typedef logic [A_W-1:0] operand_t;
  typedef logic [P_W-1:0] product_t;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder; used as a half adder with cin tied low.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic axb;

  assign axb  = a ^ b;
  assign sum  = axb ^ cin;
  assign cout = (a & b) | (cin & axb);
endmodule

// File: rtl/multiplier_4x4.sv
// Unsigned 4x4 array multiplier with a registered 8-bit product
// and a one-cycle valid flag.
module multiplier_4x4
  import mult_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  operand_t A,
  input  operand_t B,
  output product_t P,
  output logic     out_valid
);
  logic [B_W-1:0][A_W-1:0] pp;
  logic [B_W-1:0][A_W-1:0] acc;
  logic [B_W-1:1][A_W-1:0] sm;
  logic [B_W-1:1][A_W:0]   carry;
  product_t                prod;

  for (genvar j = 0; j < B_W; j++) begin : g_pp_row
    for (genvar i = 0; i < A_W; i++) begin : g_pp_col
      assign pp[j][i] = A[i] & B[j];
    end
  end

  // Row 0 contributes bit 0 directly; its upper bits seed the array.
  assign acc[0] = {1'b0, pp[0][A_W-1:1]};

  for (genvar j = 1; j < B_W; j++) begin : g_row
    assign carry[j][0] = 1'b0;
    for (genvar i = 0; i < A_W; i++) begin : g_col
      full_adder u_fa (
        .a    (pp[j][i]),
        .b    (acc[j-1][i]),
        .cin  (carry[j][i]),
        .sum  (sm[j][i]),
        .cout (carry[j][i+1])
      );
    end
    assign acc[j] = {carry[j][A_W], sm[j][A_W-1:1]};
  end

  assign prod = {acc[B_W-1], sm[3][0], sm[2][0], sm[1][0], pp[0][0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) P <= prod;
    end
  end
endmodule

// File: tb/tb_multiplier_4x4.sv
// Self-checking bench for multiplier_4x4: vector table, exhaustive
// sweep, randomized traffic against a product model, and corner sequences.
module tb_multiplier_4x4;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] mp;
  logic       mv;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       v;
    logic [7:0] p;
    logic       ov;
  } vec_t;

  vec_t tbl[10];

  multiplier_4x4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .P         (P),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] ep,
                       input logic ev);
    checks++;
    if (P !== ep || out_valid !== ev) begin
      errors++;
      $display("FAIL %s: P=%0d out_valid=%b, expected P=%0d out_valid=%b",
               name, P, out_valid, ep, ev);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic v);
    @(negedge clk);
    A = a;
    B = b;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) mp = 8'(int'(a) * int'(b));
    mv = v;
  endtask

  initial begin
    tbl[0] = '{4'd0,  4'd15, 1'b1, 8'd0,   1'b1};
    tbl[1] = '{4'd1,  4'd13, 1'b1, 8'd13,  1'b1};
    tbl[2] = '{4'd15, 4'd15, 1'b1, 8'hE1,  1'b1};
    tbl[3] = '{4'd8,  4'd8,  1'b1, 8'd64,  1'b1};
    tbl[4] = '{4'd15, 4'd1,  1'b1, 8'd15,  1'b1};
    tbl[5] = '{4'd3,  4'd5,  1'b1, 8'd15,  1'b1};
    tbl[6] = '{4'd9,  4'd7,  1'b1, 8'd63,  1'b1};
    tbl[7] = '{4'd12, 4'd11, 1'b1, 8'd132, 1'b1};
    tbl[8] = '{4'd2,  4'd2,  1'b0, 8'd132, 1'b0};
    tbl[9] = '{4'd10, 4'd6,  1'b1, 8'd60,  1'b1};

    mp = '0;
    mv = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].a, tbl[k].b, tbl[k].v);
      check($sformatf("vec%0d", k), tbl[k].p, tbl[k].ov);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive(4'(a), 4'(b), 1'b1);
        check($sformatf("sweep %0dx%0d", a, b), 8'(a * b), 1'b1);
      end
    end

    drive(4'd12, 4'd11, 1'b1);
    check("hold load", 8'd132, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(4'd2, 4'd2, 1'b0);
      check($sformatf("hold %0d", k), 8'd132, 1'b0);
    end

    drive(4'd15, 4'd15, 1'b1);
    check("stream 15x15", 8'd225, 1'b1);
    @(negedge clk);
    A = 4'd15;
    B = 4'd15;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async reset", 8'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reset held over edge", 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    mp = '0;
    mv = 1'b0;
    drive(4'd6, 4'd7, 1'b1);
    check("after reset 6x7", 8'd42, 1'b1);

    for (int k = 0; k < 4; k++) begin
      drive(k[0] ? 4'd0 : 4'd15, k[0] ? 4'd0 : 4'd15, 1'b1);
      check($sformatf("b2b %0d", k), k[0] ? 8'd0 : 8'd225, 1'b1);
    end

    for (int k = 0; k < 300; k++) begin
      logic v;
      v = 1'($urandom_range(0, 3) != 0);
      if (v)
        drive(4'($urandom), 4'($urandom), 1'b1);
      else
        drive(4'bxxxx, 4'bxxxx, 1'b0);
      check($sformatf("rand %0d", k), mp, mv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
